mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single cache port between the instruction-fetch requester (I) and the load/store requester (D) of the multicycle RISC-V core.
- Sits between the control FSM/datapath and the cache.
- Serialises transactions, registers the cache-side request, returns read data plus a one-cycle DONE to the owning requester, and flags a hung cache through a watchdog.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR_EN, 1, 1 = round-robin between I and D; 0 = fixed priority, D over I
- TIMEOUT, 255, max cycles waiting for Cache_RDY before ERR; 0 disables the watchdog

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- I_REQ  in  1  fetch request, held until I_DONE
- I_ADDR  in  ADDR_W  fetch address
- I_DONE  out  1  one-cycle pulse: fetch complete, RDATA valid
- D_REQ  in  1  data request, held until D_DONE
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_BE  in  4  byte enables
- D_DONE  out  1  one-cycle pulse: data access complete
- RDATA  out  DATA_W  read data, valid in the DONE cycle, held afterwards
- C_REQ  out  1  cache request
- C_WE  out  1  cache write enable
- C_ADDR  out  ADDR_W  cache address
- C_WDATA  out  DATA_W  cache write data
- C_BE  out  4  cache byte enables
- Cache_RDY  in  1  cache completed the current access
- Cache_VALID  in  1  cache read data valid (reads only)
- C_RDATA  in  DATA_W  cache read data
- OWNER  out  1  0 = I owns the port, 1 = D owns the port (valid while busy)
- ERR  out  1  sticky watchdog error

Behaviour:
- Reset (RST high at a CLK edge): state IDLE.
  - I_DONE, D_DONE, C_REQ, C_WE, ERR, OWNER = 0.
  - C_ADDR, C_WDATA, RDATA = 0; C_BE = 4'b0000.
  - last_grant = I, so D wins the first tie.
  - Watchdog counter = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No requester: stay in IDLE; C_REQ = 0.
  - One requester: grant it.
  - Both requesters, RR_EN = 1: grant the one opposite to last_grant.
  - Both requesters, RR_EN = 0: grant D.
  - On grant:
    - Register OWNER and the request fields into C_*. Fetches use C_WE = 0, C_BE = 4'b1111, C_WDATA = 0.
    - Set C_REQ = 1 and move to BUSY.
    - The cache sees the request the cycle after the grant decision.
- BUSY:
  - C_* are stable; requester inputs are ignored (no re-sampling).
  - Watchdog counter increments each cycle.
  - Cache_RDY = 1:
    - Capture RDATA = C_RDATA when C_WE = 0 and Cache_VALID = 1; otherwise RDATA is unchanged.
    - Drop C_REQ, update last_grant = OWNER, clear the counter, go to DONE.
  - Cache_RDY = 1 with C_WE = 0 and Cache_VALID = 0: complete anyway, keep the old RDATA, set ERR.
  - TIMEOUT != 0 and counter reaches TIMEOUT with no Cache_RDY: set ERR, keep C_REQ asserted, stay in BUSY. There is no abort, so the core stalls visibly.
- DONE (exactly one cycle):
  - Pulse I_DONE or D_DONE according to OWNER; the other DONE stays 0.
  - Go to IDLE.
  - The requester deasserts or re-presents REQ on the following cycle.
  - A REQ still high in IDLE is treated as a new request.
- Minimum transaction: grant (IDLE) → BUSY with Cache_RDY in its first cycle → DONE, i.e. 3 cycles from REQ to DONE.
- Back-to-back throughput: one transaction per 3 cycles.
- Never both DONEs at once; C_REQ is never high in IDLE or DONE.
- ERR clears only on RST.
- RST mid-transaction: abandon immediately, C_REQ = 0 on the next cycle, no DONE pulse.

Test Plan:
- Reset: after RST, all outputs are 0 and C_REQ stays 0 with no requests → hold 10 cycles, verify.
- Single fetch: I_REQ, I_ADDR = 0x100, Cache_RDY/VALID in the 1st BUSY cycle with C_RDATA = 0xDEADBEEF → C_REQ=1 with C_ADDR=0x100, C_WE=0, C_BE=4'b1111; I_DONE one cycle later, RDATA = 0xDEADBEEF; 3 cycles REQ→DONE.
- Store with stall: D_WE=1, D_ADDR=0x200, D_WDATA=0x12345678, D_BE=4'b0011, Cache_RDY after 5 cycles → C_* stable throughout, D_DONE once, RDATA unchanged.
- Contention, RR_EN=1: I_REQ and D_REQ both held for 4 transactions → grant order D, I, D, I; with RR_EN=0 → D every time while D_REQ is held.
- Watchdog, TIMEOUT=4: D load, Cache_RDY never asserted → ERR rises after 4 BUSY cycles and C_REQ stays 1; later Cache_RDY → D_DONE pulses, ERR stays 1.
- Reset mid-BUSY: RST during an I fetch → no I_DONE, C_REQ=0 next cycle, next request is granted normally with ERR=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one cache port between instruction fetch (I) and load/store (D).
// Registers the cache-side request, returns DONE/RDATA to the owner, and runs a watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_DONE,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    input  logic [3:0]        D_BE,
    output logic              D_DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              C_REQ,
    output logic              C_WE,
    output logic [ADDR_W-1:0] C_ADDR,
    output logic [DATA_W-1:0] C_WDATA,
    output logic [3:0]        C_BE,
    input  logic              Cache_RDY,
    input  logic              Cache_VALID,
    input  logic [DATA_W-1:0] C_RDATA,
    output logic              OWNER,
    output logic              ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

    state_t      state_r;
    logic        last_grant_r;
    logic [31:0] wdog_cnt_r;
    logic        grant_d_s;

    // Grant decision: D wins when alone, on a round-robin tie after I, or always in fixed priority.
    always_comb begin
        grant_d_s = 1'b0;
        if (I_REQ && D_REQ) begin
            if (RR_EN != 0) begin
                grant_d_s = ~last_grant_r;
            end else begin
                grant_d_s = 1'b1;
            end
        end else if (D_REQ) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b0;
            wdog_cnt_r   <= 32'd0;
            I_DONE       <= 1'b0;
            D_DONE       <= 1'b0;
            RDATA        <= {DATA_W{1'b0}};
            C_REQ        <= 1'b0;
            C_WE         <= 1'b0;
            C_ADDR       <= {ADDR_W{1'b0}};
            C_WDATA      <= {DATA_W{1'b0}};
            C_BE         <= 4'b0000;
            OWNER        <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    I_DONE <= 1'b0;
                    D_DONE <= 1'b0;
                    if (I_REQ || D_REQ) begin
                        OWNER      <= grant_d_s;
                        C_REQ      <= 1'b1;
                        wdog_cnt_r <= 32'd0;
                        state_r    <= BUSY;
                        if (grant_d_s) begin
                            C_WE    <= D_WE;
                            C_ADDR  <= D_ADDR;
                            C_WDATA <= D_WDATA;
                            C_BE    <= D_BE;
                        end else begin
                            C_WE    <= 1'b0;
                            C_ADDR  <= I_ADDR;
                            C_WDATA <= {DATA_W{1'b0}};
                            C_BE    <= 4'b1111;
                        end
                    end else begin
                        C_REQ <= 1'b0;
                    end
                end
                BUSY: begin
                    if (Cache_RDY) begin
                        // A read completing without valid data still finishes, but is flagged.
                        if (!C_WE) begin
                            if (Cache_VALID) begin
                                RDATA <= C_RDATA;
                            end else begin
                                ERR <= 1'b1;
                            end
                        end
                        C_REQ        <= 1'b0;
                        last_grant_r <= OWNER;
                        wdog_cnt_r   <= 32'd0;
                        I_DONE       <= ~OWNER;
                        D_DONE       <= OWNER;
                        state_r      <= DONE;
                    end else begin
                        if (wdog_cnt_r < TIMEOUT_C) begin
                            wdog_cnt_r <= wdog_cnt_r + 32'd1;
                        end
                        if ((TIMEOUT_C != 32'd0) && ((wdog_cnt_r + 32'd1) >= TIMEOUT_C)) begin
                            ERR <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    I_DONE  <= 1'b0;
                    D_DONE  <= 1'b0;
                    C_REQ   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    I_DONE  <= 1'b0;
                    D_DONE  <= 1'b0;
                    C_REQ   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin instance (TIMEOUT 255) and a fixed-priority instance (TIMEOUT 4)
// share one stimulus stream and are checked against hand-computed values.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        I_REQ = 1'b0;
    logic [31:0] I_ADDR = 32'd0;
    logic        D_REQ = 1'b0;
    logic        D_WE = 1'b0;
    logic [31:0] D_ADDR = 32'd0;
    logic [31:0] D_WDATA = 32'd0;
    logic [3:0]  D_BE = 4'b0000;
    logic        Cache_RDY = 1'b0;
    logic        Cache_VALID = 1'b0;
    logic [31:0] C_RDATA = 32'd0;

    logic        rr_i_done, rr_d_done, rr_c_req, rr_c_we, rr_owner, rr_err;
    logic [31:0] rr_rdata, rr_c_addr, rr_c_wdata;
    logic [3:0]  rr_c_be;
    logic        fp_i_done, fp_d_done, fp_c_req, fp_c_we, fp_owner, fp_err;
    logic [31:0] fp_rdata, fp_c_addr, fp_c_wdata;
    logic [3:0]  fp_c_be;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(255)) dut_rr (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_DONE(rr_i_done),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
        .D_DONE(rr_d_done), .RDATA(rr_rdata),
        .C_REQ(rr_c_req), .C_WE(rr_c_we), .C_ADDR(rr_c_addr), .C_WDATA(rr_c_wdata), .C_BE(rr_c_be),
        .Cache_RDY(Cache_RDY), .Cache_VALID(Cache_VALID), .C_RDATA(C_RDATA),
        .OWNER(rr_owner), .ERR(rr_err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(4)) dut_fp (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_DONE(fp_i_done),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
        .D_DONE(fp_d_done), .RDATA(fp_rdata),
        .C_REQ(fp_c_req), .C_WE(fp_c_we), .C_ADDR(fp_c_addr), .C_WDATA(fp_c_wdata), .C_BE(fp_c_be),
        .Cache_RDY(Cache_RDY), .Cache_VALID(Cache_VALID), .C_RDATA(C_RDATA),
        .OWNER(fp_owner), .ERR(fp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " rr outs"}, {rr_i_done, rr_d_done, rr_c_req, rr_c_we, rr_owner, rr_err, rr_c_be},
            64'd0);
        chk({tag, " rr data"}, {rr_rdata | rr_c_addr | rr_c_wdata}, 64'd0);
        chk({tag, " fp outs"}, {fp_i_done, fp_d_done, fp_c_req, fp_c_we, fp_owner, fp_err, fp_c_be},
            64'd0);
        chk({tag, " fp data"}, {fp_rdata | fp_c_addr | fp_c_wdata}, 64'd0);
    endtask

    initial begin
        // Reset, then 10 idle cycles with everything at zero.
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        chk_idle_outputs("reset");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle c_req", {62'd0, rr_c_req, fp_c_req}, 64'd0);
        end
        chk_idle_outputs("reset hold");

        // Single fetch answered in the first BUSY cycle.
        I_REQ = 1'b1;
        I_ADDR = 32'h100;
        step();
        chk("fetch c_req", {63'd0, rr_c_req}, 64'd1);
        chk("fetch c_addr", {32'd0, rr_c_addr}, 64'h100);
        chk("fetch c_we/be", {59'd0, rr_c_we, rr_c_be}, {59'd0, 1'b0, 4'b1111});
        chk("fetch c_wdata", {32'd0, rr_c_wdata}, 64'd0);
        chk("fetch owner", {62'd0, rr_owner, fp_owner}, 64'd0);
        Cache_RDY = 1'b1;
        Cache_VALID = 1'b1;
        C_RDATA = 32'hDEADBEEF;
        step();
        chk("fetch dones", {60'd0, rr_i_done, rr_d_done, fp_i_done, fp_d_done}, 64'b1010);
        chk("fetch rdata", {32'd0, rr_rdata}, 64'hDEADBEEF);
        chk("fetch c_req drop", {63'd0, rr_c_req}, 64'd0);
        I_REQ = 1'b0;
        Cache_RDY = 1'b0;
        Cache_VALID = 1'b0;
        step();
        chk("fetch done pulse", {62'd0, rr_i_done, rr_d_done}, 64'd0);

        // Store stalled for 5 BUSY cycles; request fields must stay put and RDATA untouched.
        D_REQ = 1'b1;
        D_WE = 1'b1;
        D_ADDR = 32'h200;
        D_WDATA = 32'h12345678;
        D_BE = 4'b0011;
        step();
        D_ADDR = 32'hFFFF_0000;
        D_WDATA = 32'h0;
        D_BE = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            chk("store c_req/we/own", {61'd0, rr_c_req, rr_c_we, rr_owner}, 64'b111);
            chk("store c_addr", {32'd0, rr_c_addr}, 64'h200);
            chk("store c_wdata", {32'd0, rr_c_wdata}, 64'h12345678);
            chk("store c_be", {60'd0, rr_c_be}, 64'b0011);
            chk("store no done", {62'd0, rr_i_done, rr_d_done}, 64'd0);
            if (i < 4) step();
        end
        Cache_RDY = 1'b1;
        Cache_VALID = 1'b1;
        C_RDATA = 32'h55555555;
        step();
        chk("store dones", {62'd0, rr_i_done, rr_d_done}, 64'b01);
        chk("store rdata kept", {32'd0, rr_rdata}, 64'hDEADBEEF);
        chk("store err", {63'd0, rr_err}, 64'd0);
        D_REQ = 1'b0;
        D_WE = 1'b0;
        Cache_RDY = 1'b0;
        Cache_VALID = 1'b0;
        step();
        chk("store done pulse", {62'd0, rr_i_done, rr_d_done}, 64'd0);

        // Fresh reset so both instances start with last_grant = I and ERR = 0.
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle_outputs("reset2");

        // Contention: both held, cache always ready; RR gives D,I,D,I and FP gives D every time.
        I_REQ = 1'b1;
        I_ADDR = 32'h400;
        D_REQ = 1'b1;
        D_WE = 1'b0;
        D_ADDR = 32'h800;
        D_BE = 4'b1111;
        Cache_RDY = 1'b1;
        Cache_VALID = 1'b1;
        C_RDATA = 32'hA5A5A5A5;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr grant owner", {63'd0, rr_owner}, (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr grant addr", {32'd0, rr_c_addr}, (k % 2 == 0) ? 64'h800 : 64'h400);
            chk("fp grant owner", {63'd0, fp_owner}, 64'd1);
            step();
            chk("rr cont dones", {62'd0, rr_i_done, rr_d_done}, (k % 2 == 0) ? 64'b01 : 64'b10);
            chk("fp cont dones", {62'd0, fp_i_done, fp_d_done}, 64'b01);
            step();
            chk("cont idle c_req", {62'd0, rr_c_req, fp_c_req}, 64'd0);
        end
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        Cache_RDY = 1'b0;
        Cache_VALID = 1'b0;
        step();
        chk("cont err", {62'd0, rr_err, fp_err}, 64'd0);

        // Watchdog: D load with no Cache_RDY; the TIMEOUT=4 instance flags after 4 BUSY cycles.
        D_REQ = 1'b1;
        D_WE = 1'b0;
        D_ADDR = 32'h900;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wdog err early", {62'd0, rr_err, fp_err}, 64'd0);
        end
        step();
        chk("wdog err rise", {62'd0, rr_err, fp_err}, 64'b01);
        chk("wdog c_req held", {62'd0, rr_c_req, fp_c_req}, 64'b11);
        step();
        step();
        chk("wdog stall", {60'd0, fp_c_req, fp_err, fp_d_done, fp_i_done}, 64'b1100);
        Cache_RDY = 1'b1;
        Cache_VALID = 1'b1;
        C_RDATA = 32'h0BADF00D;
        step();
        chk("wdog dones", {60'd0, fp_i_done, fp_d_done, rr_i_done, rr_d_done}, 64'b0101);
        chk("wdog err sticky", {62'd0, rr_err, fp_err}, 64'b01);
        chk("wdog rdata", {32'd0, fp_rdata}, 64'h0BADF00D);
        D_REQ = 1'b0;
        Cache_RDY = 1'b0;
        Cache_VALID = 1'b0;
        step();
        step();
        chk("wdog err kept", {63'd0, fp_err}, 64'd1);

        // Reset during a fetch: no DONE, port released, next fetch proceeds with ERR cleared.
        I_REQ = 1'b1;
        I_ADDR = 32'h180;
        step();
        chk("rst-busy c_req", {62'd0, rr_c_req, fp_c_req}, 64'b11);
        RST = 1'b1;
        step();
        chk("rst-busy released", {58'd0, rr_c_req, fp_c_req, rr_i_done, fp_i_done, rr_err, fp_err},
            64'd0);
        RST = 1'b0;
        I_ADDR = 32'h300;
        step();
        chk("rst-busy regrant", {60'd0, rr_c_req, fp_c_req, rr_i_done, fp_i_done}, 64'b1100);
        chk("rst-busy addr", {rr_c_addr, fp_c_addr}, {32'h300, 32'h300});
        chk("rst-busy err", {62'd0, rr_err, fp_err}, 64'd0);
        Cache_RDY = 1'b1;
        Cache_VALID = 1'b1;
        C_RDATA = 32'hCAFEF00D;
        step();
        chk("rst-busy dones", {60'd0, rr_i_done, rr_d_done, fp_i_done, fp_d_done}, 64'b1010);
        chk("rst-busy rdata", {rr_rdata, fp_rdata}, {32'hCAFEF00D, 32'hCAFEF00D});
        I_REQ = 1'b0;
        Cache_RDY = 1'b0;
        Cache_VALID = 1'b0;
        step();
        chk("final idle", {60'd0, rr_c_req, fp_c_req, rr_i_done, fp_i_done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
